// File: rtl/hazard_ctrl_v2.sv
// hazard_ctrl_v2: operand forwarding selects, load-use bubbles, data-memory
// wait stall with timeout watchdog, and redirects deferred across stalls.
module hazard_ctrl_v2 #(
  parameter int RA_W   = 5,
  parameter int NFWD   = 2,
  parameter int SELW   = 2,
  parameter int LD_LAT = 1,
  parameter int TMO    = 255,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [RA_W-1:0]        rs1_d,
  input  logic [RA_W-1:0]        rs2_d,
  input  logic                   use_rs1_d,
  input  logic                   use_rs2_d,
  input  logic [RA_W-1:0]        rs1_e,
  input  logic [RA_W-1:0]        rs2_e,
  input  logic [RA_W-1:0]        rd_e,
  input  logic                   we_e,
  input  logic                   ld_e,
  input  logic [NFWD*RA_W-1:0]   fwd_rd,
  input  logic [NFWD-1:0]        fwd_we,
  input  logic                   redirect_e,
  input  logic                   mem_req,
  input  logic                   mem_ack,
  output logic [SELW-1:0]        fwd_sel1,
  output logic [SELW-1:0]        fwd_sel2,
  output logic                   stall_f,
  output logic                   stall_d,
  output logic                   stall_e,
  output logic                   stall_m,
  output logic                   flush_d,
  output logic                   flush_e,
  output logic                   flush_w,
  output logic                   timeout_err,
  output logic [CNT_W-1:0]       stall_cnt
);

  localparam int WCW = $clog2(TMO + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ERR
  } state_e;

  state_e           st_q, st_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic [1:0]       lu_q, lu_d;
  logic             pend_q, pend_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;

  logic mem_wait, luse, redir;
  logic sf, sd, se, sm, fd, fe, fw;
  logic [SELW-1:0] sel1, sel2;

  // Lowest stage index wins: the nearest producer holds the newest value.
  function automatic logic [SELW-1:0] fsel(
    input logic [RA_W-1:0]      rs,
    input logic [NFWD*RA_W-1:0] rd,
    input logic [NFWD-1:0]      we
  );
    logic [SELW-1:0] s;
    s = '0;
    for (int k = NFWD - 1; k >= 0; k--) begin
      if (we[k] && rd[k*RA_W +: RA_W] == rs && rs != '0)
        s = SELW'(k + 1);
    end
    return s;
  endfunction

  assign sel1 = fsel(rs1_e, fwd_rd, fwd_we);
  assign sel2 = fsel(rs2_e, fwd_rd, fwd_we);

  assign mem_wait = mem_req & ~mem_ack;
  assign redir    = redirect_e | pend_q;
  assign luse     = ld_e & we_e & (rd_e != '0) &
                    ((use_rs1_d & (rs1_d == rd_e)) |
                     (use_rs2_d & (rs2_d == rd_e)));

  always_comb begin
    sf     = 1'b0;
    sd     = 1'b0;
    se     = 1'b0;
    sm     = 1'b0;
    fd     = 1'b0;
    fe     = 1'b0;
    fw     = 1'b0;
    lu_d   = lu_q;
    pend_d = pend_q;
    if (mem_wait) begin
      sf     = 1'b1;
      sd     = 1'b1;
      se     = 1'b1;
      sm     = 1'b1;
      fw     = 1'b1;
      pend_d = pend_q | redirect_e;
    end else if (redir) begin
      fd     = 1'b1;
      fe     = 1'b1;
      lu_d   = '0;
      pend_d = 1'b0;
    end else if (luse) begin
      sf   = 1'b1;
      sd   = 1'b1;
      fe   = 1'b1;
      lu_d = 2'(LD_LAT - 1);
    end else if (lu_q != '0) begin
      sf   = 1'b1;
      sd   = 1'b1;
      fe   = 1'b1;
      lu_d = lu_q - 1'b1;
    end
  end

  // ERR is entered after the entry cycle plus TMO counted WAIT cycles.
  always_comb begin
    st_d   = st_q;
    wcnt_d = wcnt_q;
    err_d  = err_q;
    unique case (st_q)
      IDLE: begin
        if (mem_wait) begin
          st_d   = WAIT;
          wcnt_d = '0;
        end
      end
      WAIT: begin
        if (!mem_wait) begin
          st_d = IDLE;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
          if (wcnt_d == WCW'(TMO)) begin
            st_d  = ERR;
            err_d = 1'b1;
          end
        end
      end
      ERR: begin
        if (mem_ack) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  assign scnt_d = (sf && !(&scnt_q)) ? scnt_q + 1'b1 : scnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= IDLE;
      wcnt_q <= '0;
      lu_q   <= '0;
      pend_q <= 1'b0;
      err_q  <= 1'b0;
      scnt_q <= '0;
    end else begin
      st_q   <= st_d;
      wcnt_q <= wcnt_d;
      lu_q   <= lu_d;
      pend_q <= pend_d;
      err_q  <= err_d;
      scnt_q <= scnt_d;
    end
  end

  // Outputs are forced quiet while reset is held, without waiting for a clock.
  assign fwd_sel1    = rst_n ? sel1 : '0;
  assign fwd_sel2    = rst_n ? sel2 : '0;
  assign stall_f     = rst_n & sf;
  assign stall_d     = rst_n & sd;
  assign stall_e     = rst_n & se;
  assign stall_m     = rst_n & sm;
  assign flush_d     = rst_n & fd;
  assign flush_e     = rst_n & fe;
  assign flush_w     = rst_n & fw;
  assign timeout_err = err_q;
  assign stall_cnt   = scnt_q;

endmodule
